cmem_arbiter: RTL and testbench

//  Shares the single CONV layer-memory port (cwr/crd/csel/caddr_rd/caddr_wr/cdata_wr/cdata_rd)

---
 rtl/cmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: shares the CONV layer-memory port among NREQ engines.
// Round-robin arbitration with a bounded burst lock, one command per cycle,
// registered memory command in T+1 and read-data return in T+2.
module cmem_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 20,
    parameter int unsigned SW       = 3,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*SW-1:0]   sel,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic                 cwr,
    output logic                 crd,
    output logic [SW-1:0]        csel,
    output logic [AW-1:0]        caddr_wr,
    output logic [AW-1:0]        caddr_rd,
    output logic [DW-1:0]        cdata_wr,
    input  logic [DW-1:0]        cdata_rd
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned XW = IW + 1;
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);
    localparam logic [SW-1:0] SEL_MIN = SW'(1);
    localparam logic [SW-1:0] SEL_MAX = SW'(5);

    // Arbitration state
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   owner_q;
    logic            hold_q;
    logic [CW-1:0]   cnt_q;

    // Read-return pipeline stage (T+1)
    logic [NREQ-1:0] rd_pend_q;
    logic            rd_zero_q;

    // Combinational arbitration signals
    logic            owner_req_c;
    logic            hold_ok_c;
    logic            lock_expired_c;
    logic            rr_found_c;
    logic [IW-1:0]   rr_idx_c;
    logic [XW-1:0]   cand_c;
    logic            gnt_vld_c;
    logic [IW-1:0]   gnt_idx_c;

    // Granted requester's beat
    logic [SW-1:0]   sel_g_c;
    logic [AW-1:0]   addr_g_c;
    logic [DW-1:0]   wdata_g_c;
    logic            wr_g_c;
    logic            lock_g_c;
    logic            legal_c;

    // Lock hold / expiry decision for the previous beat's owner
    always_comb begin
        owner_req_c    = req[owner_q];
        hold_ok_c      = hold_q && owner_req_c && (cnt_q < CW'(MAX_LOCK));
        lock_expired_c = hold_q && owner_req_c && !(cnt_q < CW'(MAX_LOCK));
    end

    // Round-robin search starting after last, skipping an expired lock owner
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        cand_c     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = {1'b0, last_q} + XW'(k);
            if (cand_c >= XW'(NREQ)) begin
                cand_c = cand_c - XW'(NREQ);
            end
            if (!rr_found_c && req[cand_c[IW-1:0]] &&
                !(lock_expired_c && (cand_c[IW-1:0] == owner_q))) begin
                rr_found_c = 1'b1;
                rr_idx_c   = cand_c[IW-1:0];
            end
        end
    end

    // Final grant choice; no grant while reset is asserted
    always_comb begin
        gnt_vld_c = reset && (hold_ok_c || rr_found_c);
        gnt_idx_c = hold_ok_c ? owner_q : rr_idx_c;
    end

    // One-hot grant vector
    always_comb begin
        gnt = '0;
        if (gnt_vld_c) begin
            gnt[gnt_idx_c] = 1'b1;
        end
    end

    // Select the granted requester's slice
    always_comb begin
        sel_g_c   = '0;
        addr_g_c  = '0;
        wdata_g_c = '0;
        wr_g_c    = 1'b0;
        lock_g_c  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx_c == IW'(i)) begin
                sel_g_c   = sel[i*SW +: SW];
                addr_g_c  = addr[i*AW +: AW];
                wdata_g_c = wdata[i*DW +: DW];
                wr_g_c    = wr[i];
                lock_g_c  = lock[i];
            end
        end
        legal_c = (sel_g_c >= SEL_MIN) && (sel_g_c <= SEL_MAX);
    end

    // Pointer and burst-lock bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (gnt_vld_c) begin
            last_q <= gnt_idx_c;
            if (lock_g_c) begin
                hold_q  <= 1'b1;
                owner_q <= gnt_idx_c;
                cnt_q   <= hold_ok_c ? (cnt_q + CW'(1)) : CW'(1);
            end else begin
                hold_q <= 1'b0;
                cnt_q  <= '0;
            end
        end else begin
            hold_q <= 1'b0;
            cnt_q  <= '0;
        end
    end

    // Memory command issue in T+1; illegal sel suppresses the strobe and flags err
    always_ff @(posedge clk) begin
        if (!reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            err      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
        end else begin
            cwr <= gnt_vld_c && legal_c && wr_g_c;
            crd <= gnt_vld_c && legal_c && !wr_g_c;
            err <= gnt_vld_c && !legal_c;
            if (gnt_vld_c && legal_c) begin
                csel     <= sel_g_c;
                caddr_wr <= addr_g_c;
                caddr_rd <= addr_g_c;
                cdata_wr <= wdata_g_c;
            end
        end
    end

    // Track which requester owns the read in flight during T+1
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pend_q <= '0;
            rd_zero_q <= 1'b0;
        end else begin
            rd_pend_q <= (gnt_vld_c && !wr_g_c) ? gnt : '0;
            rd_zero_q <= !legal_c;
        end
    end

    // Read return in T+2; rdata holds between returns
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_pend_q;
            if (|rd_pend_q) begin
                rdata <= rd_zero_q ? '0 : cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_cmem_arbiter.sv
// tb_cmem_arbiter: directed scenarios plus sticky random traffic, checked every
// cycle against a behavioural model of the arbiter and the layer memory.
module tb_cmem_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 12;
    localparam int DW       = 20;
    localparam int SW       = 3;
    localparam int MAX_LOCK = 16;
    localparam int MDEPTH   = 1 << AW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req, wr, lock;
    logic [NREQ*SW-1:0]   sel;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [DW-1:0]        rdata;
    logic                 err, cwr, crd;
    logic [SW-1:0]        csel;
    logic [AW-1:0]        caddr_wr, caddr_rd;
    logic [DW-1:0]        cdata_wr;
    logic [DW-1:0]        cdata_rd;

    int tests = 0;
    int fails = 0;

    // Layer memory seen by the DUT, and the model's view of what it must contain
    logic [DW-1:0] mem     [MDEPTH];
    logic [DW-1:0] ref_mem [MDEPTH];

    cmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .lock(lock),
        .sel(sel), .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err), .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd)
    );

    always #5 clk = ~clk;

    assign cdata_rd = mem[caddr_rd];

    always @(posedge clk) begin
        if (cwr === 1'b1) mem[caddr_wr] <= cdata_wr;
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 5);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_last  = NREQ - 1;
    bit              m_hold  = 1'b0;
    int              m_owner = 0;
    int              m_cnt   = 0;
    logic            e_cwr = 1'b0, e_crd = 1'b0, e_err = 1'b0;
    logic [SW-1:0]   e_csel = '0;
    logic [AW-1:0]   e_caddr_wr = '0, e_caddr_rd = '0;
    logic [DW-1:0]   e_cdata_wr = '0;
    logic [NREQ-1:0] e_rvalid = '0;
    logic [DW-1:0]   e_rdata = '0;
    int              p_rv = -1;
    logic [DW-1:0]   p_rdata = '0;

    always @(negedge clk) begin : model_p
        int              g;
        int              skip;
        int              idx;
        logic [NREQ-1:0] eg;
        logic [SW-1:0]   s;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        bit              w;
        bit              legal;

        chk("cwr",      cwr,      e_cwr);
        chk("crd",      crd,      e_crd);
        chk("err",      err,      e_err);
        chk("csel",     csel,     e_csel);
        chk("caddr_wr", caddr_wr, e_caddr_wr);
        chk("caddr_rd", caddr_rd, e_caddr_rd);
        chk("cdata_wr", cdata_wr, e_cdata_wr);
        chk("rvalid",   rvalid,   e_rvalid);
        chk("rdata",    rdata,    e_rdata);

        g = -1;
        if (reset) begin
            if (m_hold && req[m_owner] && m_cnt < MAX_LOCK) begin
                g = m_owner;
            end else begin
                skip = (m_hold && req[m_owner]) ? m_owner : -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (g < 0 && req[idx] && idx != skip) g = idx;
                end
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", gnt, eg);

        if (!reset) begin
            m_last = NREQ - 1; m_hold = 1'b0; m_cnt = 0; m_owner = 0;
            e_cwr = 1'b0; e_crd = 1'b0; e_err = 1'b0; e_csel = '0;
            e_caddr_wr = '0; e_caddr_rd = '0; e_cdata_wr = '0;
            e_rvalid = '0; e_rdata = '0; p_rv = -1;
        end else begin
            e_rvalid = '0;
            if (p_rv >= 0) begin
                e_rvalid[p_rv] = 1'b1;
                e_rdata = p_rdata;
            end
            p_rv = -1;
            e_cwr = 1'b0; e_crd = 1'b0; e_err = 1'b0;
            if (g >= 0) begin
                s = sel[g*SW +: SW];
                a = addr[g*AW +: AW];
                d = wdata[g*DW +: DW];
                w = wr[g];
                legal = (s >= 1) && (s <= 5);
                if (legal) begin
                    e_cwr = w; e_crd = !w; e_csel = s;
                    e_caddr_wr = a; e_caddr_rd = a; e_cdata_wr = d;
                end else begin
                    e_err = 1'b1;
                end
                if (!w) begin
                    p_rv = g;
                    p_rdata = legal ? ref_mem[a] : '0;
                end else if (legal) begin
                    ref_mem[a] = d;
                end
                if (lock[g]) begin
                    m_cnt = (m_hold && m_owner == g) ? m_cnt + 1 : 1;
                    m_hold = 1'b1;
                    m_owner = g;
                end else begin
                    m_hold = 1'b0;
                    m_cnt = 0;
                end
                m_last = g;
            end else begin
                m_hold = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input bit w, input int s, input int a, input int d);
        wr[i] = w;
        sel[i*SW +: SW] = SW'(s);
        addr[i*AW +: AW] = AW'(a);
        wdata[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        int v;
        int r;
        int nmis;
        logic [NREQ-1:0] exp_g;

        for (int a = 0; a < MDEPTH; a++) begin
            mem[a] = init_val(a);
            ref_mem[a] = init_val(a);
        end
        mem[12'h155] = 20'hABCDE;
        ref_mem[12'h155] = 20'hABCDE;

        reset = 1'b0; req = 3'b111; wr = '0; lock = '0;
        sel = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NREQ; i++) set_slice(i, 1'b0, 1, 0, 0);

        // reset held low with all requesting
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("rst_gnt", gnt, 3'b000);
        end
        chk("rst_strobes", {cwr, crd, err, rvalid}, 6'b0);
        chk("rst_addr", {csel, caddr_wr, caddr_rd}, 27'b0);
        chk("rst_data", {cdata_wr, rdata}, 40'b0);

        next_cycle();
        reset = 1'b1;
        at_neg();
        chk("first_gnt", gnt, 3'b001);

        // continuous round robin, no gaps
        for (int i = 1; i < 7; i++) begin
            next_cycle();
            at_neg();
            exp_g = '0;
            exp_g[i % NREQ] = 1'b1;
            chk("rr_seq", gnt, exp_g);
        end

        // single read with known memory contents
        next_cycle();
        req = 3'b010;
        set_slice(1, 1'b0, 3, 12'h155, 0);
        at_neg();
        chk("rd_gnt", gnt, 3'b010);
        next_cycle();
        req = '0;
        at_neg();
        chk("rd_cmd", {cwr, crd, csel}, {1'b0, 1'b1, 3'd3});
        chk("rd_addr", caddr_rd, 12'h155);
        next_cycle();
        at_neg();
        chk("rd_rvalid", rvalid, 3'b010);
        chk("rd_rdata", rdata, 20'hABCDE);
        next_cycle();
        at_neg();
        chk("rd_rvalid_pulse", rvalid, 3'b000);
        chk("rd_rdata_hold", rdata, 20'hABCDE);

        // burst lock against a pending competitor
        set_slice(0, 1'b0, 1, 12'h010, 0);
        set_slice(2, 1'b0, 2, 12'h020, 0);
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            req = (i == 0) ? 3'b001 : 3'b101;
            lock = 3'b001;
            at_neg();
            exp_g = (i < 16) ? 3'b001 : ((i == 16) ? 3'b100 : 3'b001);
            chk("lock_burst", gnt, exp_g);
        end

        // burst lock as the only requester: one forced idle round
        next_cycle();
        req = '0; lock = '0;
        at_neg();
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            req = 3'b001;
            lock = 3'b001;
            at_neg();
            exp_g = (i < 16) ? 3'b001 : ((i == 16) ? 3'b000 : 3'b001);
            chk("lock_solo", gnt, exp_g);
        end

        // write with illegal sel
        next_cycle();
        req = '0; lock = '0;
        at_neg();
        next_cycle();
        req = 3'b100;
        set_slice(2, 1'b1, 7, 12'h2AA, 20'h12345);
        at_neg();
        chk("ill_wr_gnt", gnt, 3'b100);
        next_cycle();
        req = '0; wr = '0;
        at_neg();
        chk("ill_wr_strobes", {cwr, crd}, 2'b00);
        chk("ill_wr_err", err, 1'b1);
        next_cycle();
        at_neg();
        chk("ill_wr_err_pulse", err, 1'b0);
        chk("ill_wr_mem", mem[12'h2AA], init_val(12'h2AA));

        // read with illegal sel returns zero data
        next_cycle();
        req = 3'b010;
        set_slice(1, 1'b0, 0, 12'h155, 0);
        at_neg();
        chk("ill_rd_gnt", gnt, 3'b010);
        next_cycle();
        req = '0;
        at_neg();
        chk("ill_rd_cmd", {err, crd}, 2'b10);
        next_cycle();
        at_neg();
        chk("ill_rd_rvalid", rvalid, 3'b010);
        chk("ill_rd_rdata", rdata, 20'h0);

        // reset while a read is in flight
        next_cycle();
        req = 3'b001;
        set_slice(0, 1'b0, 2, 12'h155, 0);
        at_neg();
        chk("rst_rd_gnt", gnt, 3'b001);
        next_cycle();
        req = 3'b111;
        reset = 1'b0;
        at_neg();
        chk("rst_rd_gnt_low", gnt, 3'b000);
        chk("rst_rd_crd", crd, 1'b1);
        next_cycle();
        reset = 1'b1;
        req = '0;
        at_neg();
        chk("rst_rd_rvalid", rvalid, 3'b000);
        chk("rst_rd_strobes", {cwr, crd, err}, 3'b000);

        // sticky random traffic
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 9) == 0) lock[i] = ~lock[i];
                wr[i] = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 9);
                if (r < 7)       v = $urandom_range(1, 5);
                else if (r == 7) v = 0;
                else             v = $urandom_range(6, 7);
                sel[i*SW +: SW] = SW'(v);
                addr[i*AW +: AW] = AW'($urandom_range(0, 63));
                wdata[i*DW +: DW] = DW'($urandom);
            end
            reset = ($urandom_range(0, 199) != 0);
        end

        // drain and compare memory contents
        next_cycle();
        req = '0; lock = '0; reset = 1'b1;
        repeat (4) next_cycle();
        nmis = 0;
        for (int a = 0; a < MDEPTH; a++) begin
            if (mem[a] !== ref_mem[a]) nmis++;
        end
        chk("mem_final", nmis, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
